// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use stall, branch flush and
// multi-cycle (MUL/DIV) stall. Define HAZARD_PERF_CNT_EN to add stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RD_M,
  input  logic [ADDR_W-1:0] RD_W,
  input  logic [ADDR_W-1:0] RD_E,
  input  logic [ADDR_W-1:0] Rs1_D,
  input  logic [ADDR_W-1:0] Rs2_D,
  input  logic [ADDR_W-1:0] Rs1_E,
  input  logic [ADDR_W-1:0] Rs2_E,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MulStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              MulBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned CntW    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned LatM2   = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam bit          MulLong = (MUL_LAT > 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lw_stall, mul_stall;
  logic [1:0]        fwd_a, fwd_b;

  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))      fwd_a = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))      fwd_b = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) fwd_b = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // cnt holds the stall cycles still owed after the current one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MulStartE && MulLong) begin
          state_d   = StBusy;
          cnt_d     = CntW'(LatM2);
          mul_stall = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CntW'(1);
          mul_stall = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole reset window, not just state.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    BubbleM   = 1'b0;
    MulBusy   = 1'b0;
    if (rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = lw_stall | mul_stall;
      StallD    = lw_stall | mul_stall;
      StallE    = mul_stall;
      BubbleM   = mul_stall;
      FlushD    = PCSrcE & ~mul_stall;
      FlushE    = (lw_stall | PCSrcE) & ~mul_stall;
      MulBusy   = (state_q == StBusy);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MUL_LAT=4): vector table, hand-written multi-cycle
// sequences, then random stimulus against an occupancy-based reference model.
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteM, RegWriteW;
  logic [AW-1:0] RD_M, RD_W, RD_E, Rs1_D, Rs2_D, Rs1_E, Rs2_E;
  logic          ResultSrcE0, PCSrcE, MulStartE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, BubbleM, MulBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int age      = -1;  // cycles since current multi-cycle op entered EX; -1 = none
  int age_nxt  = -1;

  hazard_ctrl #(.ADDR_W(AW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM), .MulBusy(MulBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rwm, rww;
    logic [4:0] rd_m, rd_w, rd_e, rs1_d, rs2_d, rs1_e, rs2_e;
    logic       ld, pc;
    logic [1:0] fa, fb;
    logic       stall, flush_d, flush_e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    RD_M = '0; RD_W = '0; RD_E = '0;
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MulStartE = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    RegWriteM = v.rwm; RegWriteW = v.rww;
    RD_M = v.rd_m; RD_W = v.rd_w; RD_E = v.rd_e;
    Rs1_D = v.rs1_d; Rs2_D = v.rs2_d; Rs1_E = v.rs1_e; Rs2_E = v.rs2_e;
    ResultSrcE0 = v.ld; PCSrcE = v.pc; MulStartE = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fwdA"}, ForwardAE, 0);
    chk({tag, "_fwdB"}, ForwardBE, 0);
    chk({tag, "_stallF"}, StallF, 0);
    chk({tag, "_stallD"}, StallD, 0);
    chk({tag, "_stallE"}, StallE, 0);
    chk({tag, "_flushD"}, FlushD, 0);
    chk({tag, "_flushE"}, FlushE, 0);
    chk({tag, "_bubbleM"}, BubbleM, 0);
    chk({tag, "_busy"}, MulBusy, 0);
  endtask

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // An op occupies EX for LAT cycles (ages 0..LAT-1); it stalls on all but its last cycle
  // and the unit reports busy on every cycle after the first.
  task automatic model_check();
    int   cur;
    logic ms, lw, busy;
    cur = age;
    if (cur < 0 && MulStartE && LAT > 1) cur = 0;
    ms   = (cur >= 0) && (cur <= LAT - 2);
    busy = (cur >= 1);
    lw   = ResultSrcE0 && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    chk("rnd_fwdA", ForwardAE, fwd(Rs1_E));
    chk("rnd_fwdB", ForwardBE, fwd(Rs2_E));
    chk("rnd_stallF", StallF, lw | ms);
    chk("rnd_stallD", StallD, lw | ms);
    chk("rnd_stallE", StallE, ms);
    chk("rnd_bubbleM", BubbleM, ms);
    chk("rnd_flushD", FlushD, PCSrcE & ~ms);
    chk("rnd_flushE", FlushE, (lw | PCSrcE) & ~ms);
    chk("rnd_busy", MulBusy, busy);
    age_nxt = (cur >= 0 && cur + 1 < LAT) ? cur + 1 : -1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0,
                2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0,
                2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0,
                2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0,
                2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1,
                2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0,
                2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 5'd4, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd4, 1'b0, 1'b0,
                2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1,
                2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0,
                2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    // Reset held with hazard-producing inputs: every output must still read 0.
    rst = 1'b0;
    clear_inputs();
    RegWriteM = 1'b1; RD_M = 5'd5; Rs1_E = 5'd5; ResultSrcE0 = 1'b1; RD_E = 5'd7;
    Rs2_D = 5'd7; PCSrcE = 1'b1; MulStartE = 1'b1;
    #12;
    chk_zero("rst");
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_rst_stall", stall_cnt, 0);
    chk("perf_rst_flush", flush_cnt, 0);
    ResultSrcE0 = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
    repeat (3) begin @(posedge clk); #1; end
    clear_inputs();
    PCSrcE = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("perf_stall_cnt", stall_cnt, 3);
    chk("perf_flush_cnt", flush_cnt, 4);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_fwdA", i), ForwardAE, vecs[i].fa);
      chk($sformatf("vec%0d_fwdB", i), ForwardBE, vecs[i].fb);
      chk($sformatf("vec%0d_stallF", i), StallF, vecs[i].stall);
      chk($sformatf("vec%0d_stallD", i), StallD, vecs[i].stall);
      chk($sformatf("vec%0d_stallE", i), StallE, 0);
      chk($sformatf("vec%0d_flushD", i), FlushD, vecs[i].flush_d);
      chk($sformatf("vec%0d_flushE", i), FlushE, vecs[i].flush_e);
      chk($sformatf("vec%0d_busy", i), MulBusy, 0);
      @(posedge clk); #1;
    end
    clear_inputs();

    // Single op, start held until StallE falls.
    for (int c = 0; c < 5; c++) begin
      MulStartE = (c <= 3);
      @(negedge clk);
      chk($sformatf("mul_c%0d_stallE", c), StallE, (c < 3));
      chk($sformatf("mul_c%0d_stallF", c), StallF, (c < 3));
      chk($sformatf("mul_c%0d_bubbleM", c), BubbleM, (c < 3));
      chk($sformatf("mul_c%0d_busy", c), MulBusy, (c >= 1 && c <= 3));
      @(posedge clk); #1;
    end

    // Back-to-back ops: second op starts right after BUSY exits.
    MulStartE = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_c%0d_stallE", c), StallE, ((c % 4) != 3));
      chk($sformatf("b2b_c%0d_busy", c), MulBusy, ((c % 4) != 0));
      @(posedge clk); #1;
    end
    MulStartE = 1'b0;
    @(negedge clk);
    chk("b2b_end_busy", MulBusy, 0);
    chk("b2b_end_stallE", StallE, 0);
    @(posedge clk); #1;

    // Branch plus load-use while the multi-cycle op stalls: flushes suppressed until last cycle.
    for (int c = 0; c < 5; c++) begin
      MulStartE = (c <= 3);
      PCSrcE = (c <= 3); ResultSrcE0 = (c <= 3); RD_E = 5'd7; Rs1_D = 5'd7;
      @(negedge clk);
      chk($sformatf("mfl_c%0d_flushD", c), FlushD, (c == 3));
      chk($sformatf("mfl_c%0d_flushE", c), FlushE, (c == 3));
      chk($sformatf("mfl_c%0d_stallE", c), StallE, (c < 3));
      chk($sformatf("mfl_c%0d_stallF", c), StallF, (c <= 3));
      @(posedge clk); #1;
    end
    clear_inputs();

    // Reset in the second BUSY cycle aborts the op.
    MulStartE = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    RegWriteM = 1'b1; RD_M = 5'd5; Rs1_E = 5'd5; PCSrcE = 1'b1;
    #1;
    chk("rstb_pre_busy", MulBusy, 1);
    rst = 1'b0;
    #1;
    chk_zero("rstb");
    #1;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rstb_post_busy", MulBusy, 0);
    chk("rstb_post_stallE", StallE, 0);
    chk("rstb_post_stallF", StallF, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstb_post2_busy", MulBusy, 0);
    @(posedge clk); #1;

    age = -1;
    for (int n = 0; n < 400; n++) begin
      RegWriteM   = ($urandom_range(0, 1) == 0);
      RegWriteW   = ($urandom_range(0, 1) == 0);
      RD_M        = 5'($urandom_range(0, 3));
      RD_W        = 5'($urandom_range(0, 3));
      RD_E        = 5'($urandom_range(0, 3));
      Rs1_D       = 5'($urandom_range(0, 3));
      Rs2_D       = 5'($urandom_range(0, 3));
      Rs1_E       = 5'($urandom_range(0, 3));
      Rs2_E       = 5'($urandom_range(0, 3));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 5) == 0);
      MulStartE   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      model_check();
      @(posedge clk);
      age = age_nxt;
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage RISC-V pipeline: the successor to the forwarding-only unit. It generates EX-stage operand forwarding selects, load-use stalls, taken-branch flushes, and multi-cycle stalls for long-latency execute ops (MUL/DIV) through an internal busy counter. It sits beside the datapath and drives the stall/flush/enable inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- ADDR_W, 5, register-address width; register 0 is hard-wired zero and never forwarded or stalled on
- MUL_LAT, 3, total cycles a multi-cycle op occupies EX (≥1; 1 = no stall)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteM, RegWriteW  in  1  register write enables in MEM / WB
- RD_M, RD_W, RD_E  in  ADDR_W  destination registers in MEM / WB / EX
- Rs1_D, Rs2_D, Rs1_E, Rs2_E  in  ADDR_W  source registers in ID / EX
- ResultSrcE0  in  1  instruction in EX is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- MulStartE  in  1  instruction in EX is a multi-cycle op
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
- FlushD, FlushE  out  1  clear IF-ID / ID-EX registers
- BubbleM  out  1  load a bubble into EX-MEM
- MulBusy  out  1  multi-cycle FSM in BUSY

## Operation
- Forwarding per operand X∈{A:Rs1_E, B:Rs2_E}: 10 if RegWriteM & RD_M≠0 & RD_M==RsX_E; else 01 if RegWriteW & RD_W≠0 & RD_W==RsX_E; else 00. MEM wins over WB.
- lwStall = ResultSrcE0 & RD_E≠0 & (RD_E==Rs1_D | RD_E==Rs2_D).
- FSM states IDLE, BUSY; down-counter cnt, width clog2(MUL_LAT) (min 1).
- IDLE: if MulStartE & MUL_LAT>1 → BUSY, cnt←MUL_LAT−2. Else stay.
- BUSY: cnt≠0 → cnt←cnt−1; cnt==0 → IDLE. MulStartE ignored in BUSY (held high by the stalled op).
- mulStall = (IDLE & MulStartE & MUL_LAT>1) | (BUSY & cnt≠0). Total stall cycles per op = MUL_LAT−1.
- StallF = StallD = lwStall | mulStall; StallE = BubbleM = mulStall.
- FlushD = PCSrcE & ~mulStall; FlushE = (lwStall | PCSrcE) & ~mulStall.
- Simultaneous lwStall and PCSrcE: both FlushD and FlushE asserted; the stall is discarded along with the flushed instruction.
- MulBusy = (state==BUSY).

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state; zero-cycle latency.
- While rst low: state=IDLE, cnt=0, and all outputs forced to 0 asynchronously (including forwarding selects). Reset mid-BUSY aborts the op; first cycle after release is IDLE.
- MUL_LAT=3, MulStartE rising at cycle 0: mulStall high in cycles 0,1; low in cycle 2; MulBusy high in cycles 1,2; IDLE in cycle 3.
- Back-to-back multi-cycle ops: the second op's MulStartE is seen in IDLE in the cycle after BUSY exits, with no gap cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0]. stall_cnt increments each cycle StallF=1; flush_cnt increments each cycle FlushE=1. Both saturate at 0xFFFFFFFF and are cleared by rst.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5, Rs2_E=0 → ForwardAE=10, ForwardBE=00; with RD_M=0 instead → ForwardAE=01.
- ResultSrcE0=1, RD_E=7, Rs2_D=7 → StallF=StallD=FlushE=1, StallE=0; with RD_E=0 → all 0.
- MUL_LAT=4, MulStartE held until StallE falls → StallE high for exactly 3 cycles, MulBusy for 3, FSM back in IDLE on the 5th cycle.
- PCSrcE=1 with lwStall condition true → FlushD=FlushE=1; the same inputs during mulStall → FlushD=FlushE=0, StallE=1.
- rst driven low in the 2nd cycle of BUSY (MUL_LAT=4) → all outputs 0 immediately; after release with MulStartE=0 → MulBusy=0, no stall.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls and 1 taken branch → stall_cnt=3, flush_cnt=4; a counter preloaded near saturation stays at 0xFFFFFFFF.
